// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Purpose  : Pipeline hazard controller for the 5-stage MIPS core. Sits in
//             ID and drives the PC / IF/ID write enables, the IF/ID flush,
//             the ID/EX bubble and the back-end freeze. Detects load-use,
//             branch-in-ID operand hazards (EX ALU, EX load, MEM load),
//             taken-branch flushes and data-memory wait states, with a wait
//             timeout that raises a sticky error flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    REG_AW   register-address width (address 0 never a hazard source)
//    MEM_TMO  max consecutive mem-wait cycles before timeout (1..255)
//    TMO_W    width of the wait counter (must hold MEM_TMO)
//  Ports
//    clk, reset                 rising-edge clock, sync active-high reset
//    if_id_rs, if_id_rt         source registers of the instruction in ID
//    id_branch, id_br_taken     ID holds beq/bne, comparator result
//    id_ex_memread/regwrite/dst EX-stage instruction info
//    ex_mem_memread/dst         MEM-stage instruction info
//    mem_req, mem_ready         data-memory handshake in MEM
//    pc_write, if_id_write      front-end write enables
//    if_id_flush                zero IF/ID (taken branch)
//    id_ex_bubble               insert NOP into ID/EX
//    pipe_freeze                hold ID/EX, EX/MEM, MEM/WB
//    mem_timeout                sticky wait-timeout error
//    wait_cnt                   current mem-wait cycle count
//  Optional build macro
//    HAZ_PERF_CNT_EN            adds stall_cycles, flush_cycles and
//                               freeze_cycles saturating 32-bit counters
// ============================================================================
module hazard_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int MEM_TMO = 15,
  parameter int TMO_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              id_branch,
  input  logic              id_br_taken,
  input  logic              id_ex_memread,
  input  logic              id_ex_regwrite,
  input  logic [REG_AW-1:0] id_ex_dst,
  input  logic              ex_mem_memread,
  input  logic [REG_AW-1:0] ex_mem_dst,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic              mem_timeout,
  output logic [TMO_W-1:0]  wait_cnt
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles,
  output logic [31:0]       freeze_cycles
`endif
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TMO);
  localparam logic [TMO_W-1:0] CNT_ONE   = TMO_W'(1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TMO_W-1:0]  cnt_nxt;
  logic              timeout_nxt;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  function automatic logic reg_match(input logic [REG_AW-1:0] d,
                                     input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (d != '0) && ((d == a) || (d == b));
  endfunction

  logic haz_lu;
  logic haz_bex;
  logic haz_bmm;
  logic haz_stall;
  logic mem_wait;
  logic br_flush;

  assign haz_lu    = id_ex_memread & reg_match(id_ex_dst, if_id_rs, if_id_rt);
  // A load feeding a branch shows up here first (EX), then as haz_bmm (MEM),
  // giving the required two stall cycles without extra state.
  assign haz_bex   = id_branch & id_ex_regwrite &
                     reg_match(id_ex_dst, if_id_rs, if_id_rt);
  assign haz_bmm   = id_branch & ex_mem_memread &
                     reg_match(ex_mem_dst, if_id_rs, if_id_rt);
  assign haz_stall = haz_lu | haz_bex | haz_bmm;
  // Once the timeout flag is set the wait is ignored so the pipe can drain.
  assign mem_wait  = mem_req & ~mem_ready & ~mem_timeout;
  assign br_flush  = id_branch & id_br_taken;

  // --------------------------------------------------------------------------
  // Output decode: reset > mem wait > stall > taken-branch flush > run
  // --------------------------------------------------------------------------
  logic out_stall;
  logic out_flush;
  logic out_freeze;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    out_stall    = 1'b0;
    out_flush    = 1'b0;
    out_freeze   = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_wait) begin
      // Freeze wins over a coincident stall; the stall is re-evaluated once
      // the memory releases the pipe.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      pipe_freeze  = 1'b1;
      out_freeze   = 1'b1;
    end else if (haz_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      out_stall    = 1'b1;
    end else if (br_flush) begin
      // IF/ID stays write-enabled; the flush overrides the loaded value.
      if_id_flush  = 1'b1;
      out_flush    = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Memory-wait FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = wait_cnt;
    timeout_nxt = mem_timeout;
    case (state)
      ST_RUN: begin
        if (mem_wait) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (mem_ready || !mem_req) begin
          // Access completed, or the requester withdrew: leave the wait.
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (wait_cnt >= TMO_LIMIT) begin
          state_nxt   = ST_RUN;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = wait_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating outcome counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles  <= '0;
      flush_cycles  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (out_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (out_flush && (flush_cycles != '1))
        flush_cycles <= flush_cycles + 32'd1;
      if (out_freeze && (freeze_cycles != '1))
        freeze_cycles <= freeze_cycles + 32'd1;
    end
  end
`else
  // Outcome classes only feed the optional counters.
  logic unused_outcomes;
  assign unused_outcomes = out_stall ^ out_flush ^ out_freeze;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_unit
//  Purpose  : Directed, table-driven bench for hazard_ctrl_unit plus short
//             hand-written multi-cycle sequences (load->branch, mem wait,
//             reset mid-wait, timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;
  localparam int AW  = 5;
  localparam int TMO = 4;
  localparam int TW  = 8;

  // Packed outcome order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11100;
  localparam logic [4:0] O_FRZ   = 5'b00001;
  localparam logic [4:0] O_RST   = 5'b00010;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] if_id_rs, if_id_rt, id_ex_dst, ex_mem_dst;
  logic          id_branch, id_br_taken, id_ex_memread, id_ex_regwrite;
  logic          ex_mem_memread, mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic          mem_timeout;
  logic [TW-1:0] wait_cnt;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_cycles, freeze_cycles;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(AW), .MEM_TMO(TMO), .TMO_W(TW)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_branch(id_branch), .id_br_taken(id_br_taken),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
    .id_ex_dst(id_ex_dst),
    .ex_mem_memread(ex_mem_memread), .ex_mem_dst(ex_mem_dst),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .wait_cnt(wait_cnt)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
    .freeze_cycles(freeze_cycles)
`endif
  );

  typedef struct {
    string         name;
    logic [AW-1:0] rs, rt;
    logic          br, tk, exmr, exrw;
    logic [AW-1:0] exd;
    logic          mmmr;
    logic [AW-1:0] mmd;
    logic          mreq, mrdy;
    logic [4:0]    exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(string nm, logic [AW-1:0] rs, logic [AW-1:0] rt,
                              logic br, logic tk, logic exmr, logic exrw,
                              logic [AW-1:0] exd, logic mmmr, logic [AW-1:0] mmd,
                              logic mreq, logic mrdy, logic [4:0] exp);
    vec_t v;
    v.name = nm; v.rs = rs; v.rt = rt; v.br = br; v.tk = tk;
    v.exmr = exmr; v.exrw = exrw; v.exd = exd; v.mmmr = mmmr; v.mmd = mmd;
    v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    if_id_rs = v.rs; if_id_rt = v.rt; id_branch = v.br; id_br_taken = v.tk;
    id_ex_memread = v.exmr; id_ex_regwrite = v.exrw; id_ex_dst = v.exd;
    ex_mem_memread = v.mmmr; ex_mem_dst = v.mmd;
    mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  task automatic idle();
    apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
  endtask

  // Drive just after a rising edge; checks happen on the following falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [4:0] exp);
    logic [4:0] got;
    @(negedge clk);
    got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: outputs {pcw,ifw,flush,bubble,freeze}=%b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [TW-1:0] exp);
    n_vec++;
    if (wait_cnt !== exp) begin
      n_err++;
      $display("FAIL %s: wait_cnt=%0d expected %0d", nm, wait_cnt, exp);
    end
  endtask

  task automatic chk_to(input string nm, input logic exp);
    n_vec++;
    if (mem_timeout !== exp) begin
      n_err++;
      $display("FAIL %s: mem_timeout=%b expected %b", nm, mem_timeout, exp);
    end
  endtask

  initial begin
    //            name          rs  rt br tk exmr exrw exd mmmr mmd mreq mrdy exp
    vt[0]  = mk("quiet",        0,  0, 0, 0, 0,   0,   0,  0,   0,  0,   0,   O_RUN);
    vt[1]  = mk("lu_rs",        8,  2, 0, 0, 1,   1,   8,  0,   0,  0,   0,   O_STALL);
    vt[2]  = mk("lu_rt",        3,  8, 0, 0, 1,   1,   8,  0,   0,  0,   0,   O_STALL);
    vt[3]  = mk("lu_r0",        0,  4, 0, 0, 1,   1,   0,  0,   0,  0,   0,   O_RUN);
    vt[4]  = mk("lu_nomatch",   9, 10, 0, 0, 1,   1,   8,  0,   0,  0,   0,   O_RUN);
    vt[5]  = mk("bex_alu",      5,  6, 1, 0, 0,   1,   5,  0,   0,  0,   0,   O_STALL);
    vt[6]  = mk("alu_nobr",     5,  6, 0, 0, 0,   1,   5,  0,   0,  0,   0,   O_RUN);
    vt[7]  = mk("bmm_rt",       1,  7, 1, 0, 0,   0,   0,  1,   7,  0,   0,   O_STALL);
    vt[8]  = mk("mmload_nobr",  1,  7, 0, 0, 0,   0,   0,  1,   7,  0,   0,   O_RUN);
    vt[9]  = mk("br_ex_r0",     0,  3, 1, 0, 0,   1,   0,  0,   0,  0,   0,   O_RUN);
    vt[10] = mk("br_taken",     4,  3, 1, 1, 0,   0,   0,  0,   0,  0,   0,   O_FLUSH);
    vt[11] = mk("taken_bex",    4,  3, 1, 1, 0,   1,   4,  0,   0,  0,   0,   O_STALL);
    vt[12] = mk("br_nottaken",  4,  3, 1, 0, 0,   1,   9,  0,   0,  0,   0,   O_RUN);
    vt[13] = mk("tk_nobranch",  4,  3, 0, 1, 0,   0,   0,  0,   0,  0,   0,   O_RUN);
    vt[14] = mk("mem_rdy_lu",   8,  0, 0, 0, 1,   0,   8,  0,   0,  1,   1,   O_STALL);
    vt[15] = mk("bmm_r0",       0,  0, 1, 1, 0,   0,   0,  1,   0,  0,   0,   O_FLUSH);

    // ---- reset state ----
    reset = 1'b1;
    idle();
    next_cycle();
    chk_out("reset_outputs", O_RST);
    chk_cnt("reset_wait_cnt", 0);
    chk_to("reset_timeout", 1'b0);
    next_cycle();
    reset = 1'b0;

    // ---- single-cycle table ----
    for (int i = 0; i < NV; i++) begin
      next_cycle();
      apply(vt[i]);
      chk_out(vt[i].name, vt[i].exp);
    end

    // ---- load-use, then load moves to MEM with no branch ----
    next_cycle(); apply(mk("", 8, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0));
    chk_out("lu_seq_c1", O_STALL);
    next_cycle(); apply(mk("", 8, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0));
    chk_out("lu_seq_c2", O_RUN);

    // ---- load feeding a branch: BEX, BMM, then taken flush ----
    next_cycle(); apply(mk("", 2, 9, 1, 0, 1, 1, 9, 0, 0, 0, 0, 0));
    chk_out("ldbr_c1_bex", O_STALL);
    next_cycle(); apply(mk("", 2, 9, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0));
    chk_out("ldbr_c2_bmm", O_STALL);
    next_cycle(); apply(mk("", 2, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_out("ldbr_c3_flush", O_FLUSH);

    // ---- mem wait 3 cycles with a coincident load-use ----
    for (int k = 0; k < 3; k++) begin
      next_cycle(); apply(mk("", 8, 0, 0, 0, 1, 1, 8, 0, 0, 1, 0, 0));
      chk_out("mw_freeze", O_FRZ);
      chk_cnt("mw_cnt", TW'(k));
    end
    next_cycle(); mem_ready = 1'b1;
    chk_out("mw_release_lu", O_STALL);
    chk_cnt("mw_cnt_last", 3);
    next_cycle(); idle();
    chk_out("mw_after", O_RUN);
    chk_cnt("mw_cnt_cleared", 0);

    // ---- reset asserted mid-wait ----
    next_cycle(); apply(mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    chk_out("rw_freeze1", O_FRZ);
    next_cycle();
    chk_out("rw_freeze2", O_FRZ);
    next_cycle(); reset = 1'b1;
    chk_out("rw_forced", O_RST);
    chk_cnt("rw_cnt_before", 2);
    next_cycle();
    chk_out("rw_forced2", O_RST);
    chk_cnt("rw_cnt_reset", 0);
    next_cycle(); reset = 1'b0; idle();
    chk_out("rw_run", O_RUN);
    next_cycle();
    chk_out("rw_run2", O_RUN);
    chk_cnt("rw_stays_run", 0);

    // ---- timeout: MEM_TMO=4, ready never arrives ----
    for (int k = 0; k <= TMO; k++) begin
      next_cycle(); apply(mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      chk_out("to_freeze", O_FRZ);
      chk_cnt("to_cnt", TW'(k));
      chk_to("to_not_yet", 1'b0);
    end
    next_cycle();
    chk_out("to_released", O_RUN);
    chk_to("to_set", 1'b1);
    chk_cnt("to_cnt_zero", 0);
    next_cycle(); apply(mk("", 6, 0, 0, 0, 1, 1, 6, 0, 0, 1, 0, 0));
    chk_out("to_masked_lu", O_STALL);
    chk_to("to_sticky", 1'b1);
    next_cycle(); reset = 1'b1;
    chk_out("to_reset_forced", O_RST);
    next_cycle(); reset = 1'b0; idle(); mem_req = 1'b1;
    chk_to("to_cleared", 1'b0);
    chk_out("to_wait_again", O_FRZ);

    next_cycle(); idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
